// File: rtl/pc_sequencer_if.sv
// Decode-stage control bundle and fetch-side results exchanged with pc_sequencer.
// The decode/driver side takes the master modport; the sequencer takes slave.
interface pc_sequencer_if;
  logic        InstrValid;
  logic        Stall;
  logic        Branch;
  logic        Jump;
  logic        JumpRegister;
  logic        Link;
  logic [3:0]  ALUOp;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [31:0] Imm;
  logic [25:0] Target;
  logic [31:0] ID_PC4;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic        LinkWrite;
  logic [31:0] LinkAddr;
  logic        Redirect;

  modport master (
    output InstrValid, Stall, Branch, Jump, JumpRegister, Link, ALUOp,
           RsData, RtData, Imm, Target, ID_PC4,
    input  PC, PCPlus4, Flush, LinkWrite, LinkAddr, Redirect
  );

  modport slave (
    input  InstrValid, Stall, Branch, Jump, JumpRegister, Link, ALUOp,
           RsData, RtData, Imm, Target, ID_PC4,
    output PC, PCPlus4, Flush, LinkWrite, LinkAddr, Redirect
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: resolves branches/jumps from decode, redirects fetch,
// squashes the wrong-path fetch for one cycle and raises the $31 link write for jal/jalr.
module pc_sequencer (
  input  logic            Clk,
  input  logic            Reset,
  pc_sequencer_if.slave   bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] target;
  logic        cond_true;
  logic        taken;
  logic        accepted;
  logic        redirect;
  logic        link_write;
  logic [31:0] link_addr;

  assign pc_plus4 = pc_reg + 32'd4;
  assign accepted = bus.InstrValid && !bus.Stall && (state == RUN);

  // Branch conditions are signed; unknown condition codes never take.
  always_comb begin
    cond_true = 1'b0;
    case (bus.ALUOp)
      4'b1011: cond_true = (bus.RsData == bus.RtData);
      4'b1100: cond_true = (bus.RsData != bus.RtData);
      4'b1101: cond_true = ($signed(bus.RsData) >  32'sd0);
      4'b1110: cond_true = ($signed(bus.RsData) <= 32'sd0);
      4'b1010: cond_true = ($signed(bus.RsData) >= 32'sd0);
      4'b1111: cond_true = ($signed(bus.RsData) <  32'sd0);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    taken = bus.Jump || (bus.Branch && cond_true);
    if (bus.Jump && bus.JumpRegister)
      target = {bus.RsData[31:2], 2'b00};
    else if (bus.Jump)
      target = {bus.ID_PC4[31:28], bus.Target, 2'b00};
    else
      target = bus.ID_PC4 + (bus.Imm << 2);
  end

  assign redirect = accepted && taken;

  always_comb begin
    state_next = state;
    pc_next    = pc_plus4;
    case (state)
      RUN:     if (redirect) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
    if (bus.Stall)
      pc_next = pc_reg;
    else if (redirect)
      pc_next = target;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= RUN;
      pc_reg     <= 32'h0;
      link_write <= 1'b0;
      link_addr  <= 32'h0;
    end else begin
      state      <= state_next;
      pc_reg     <= pc_next;
      link_write <= redirect && bus.Jump && bus.Link;
      if (redirect && bus.Jump && bus.Link)
        link_addr <= bus.ID_PC4;
    end
  end

  assign bus.PC        = pc_reg;
  assign bus.PCPlus4   = pc_plus4;
  assign bus.Flush     = (state == FLUSH);
  assign bus.LinkWrite = link_write;
  assign bus.LinkAddr  = link_addr;
  assign bus.Redirect  = redirect;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PC/flush/link values.
module tb_pc_sequencer;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   compare_count = 0;
  int   mismatch_count = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearControl();
    bus.InstrValid   = 1'b0;
    bus.Stall        = 1'b0;
    bus.Branch       = 1'b0;
    bus.Jump         = 1'b0;
    bus.JumpRegister = 1'b0;
    bus.Link         = 1'b0;
    bus.ALUOp        = 4'b0000;
    bus.RsData       = 32'h0;
    bus.RtData       = 32'h0;
    bus.Imm          = 32'h0;
    bus.Target       = 26'h0;
    bus.ID_PC4       = 32'h0;
  endtask

  task automatic applyStimulus(input logic branch, input logic jump, input logic jr,
                               input logic link, input logic [3:0] op,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] imm, input logic [25:0] tgt,
                               input logic [31:0] pc4);
    bus.InstrValid   = 1'b1;
    bus.Branch       = branch;
    bus.Jump         = jump;
    bus.JumpRegister = jr;
    bus.Link         = link;
    bus.ALUOp        = op;
    bus.RsData       = rs;
    bus.RtData       = rt;
    bus.Imm          = imm;
    bus.Target       = tgt;
    bus.ID_PC4       = pc4;
    #1;
  endtask

  initial begin
    clearControl();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checkOutput("reset_pc", bus.PC, 32'h0);
    checkOutput("reset_flush", {31'b0, bus.Flush}, 32'h0);
    checkOutput("reset_linkwrite", {31'b0, bus.LinkWrite}, 32'h0);
    checkOutput("reset_linkaddr", bus.LinkAddr, 32'h0);

    // Idle sequential fetch
    tick();
    checkOutput("idle_pc4", bus.PC, 32'h4);
    tick();
    checkOutput("idle_pc8", bus.PC, 32'h8);
    tick();
    checkOutput("idle_pcC", bus.PC, 32'hC);
    checkOutput("idle_flush", {31'b0, bus.Flush}, 32'h0);

    // beq taken backwards: 0x10 + (-2 << 2) = 0x08
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 32'd5, 32'd5, 32'hFFFFFFFE, 26'h0, 32'h10);
    checkOutput("beq_redirect", {31'b0, bus.Redirect}, 32'h1);
    tick();
    clearControl();
    checkOutput("beq_pc", bus.PC, 32'h8);
    checkOutput("beq_flush", {31'b0, bus.Flush}, 32'h1);
    tick();
    checkOutput("beq_after_pc", bus.PC, 32'hC);
    checkOutput("beq_after_flush", {31'b0, bus.Flush}, 32'h0);

    // bltz with most-negative Rs: 0x100 + (4 << 2) = 0x110
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h80000000, 32'h0, 32'h4, 26'h0, 32'h100);
    checkOutput("bltz_redirect", {31'b0, bus.Redirect}, 32'h1);
    tick();
    clearControl();
    checkOutput("bltz_pc", bus.PC, 32'h110);
    tick();
    checkOutput("bltz_after_pc", bus.PC, 32'h114);

    // bgtz with Rs=0, bne with equal operands, unlisted code: none taken
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1101, 32'h0, 32'h0, 32'h4, 26'h0, 32'h200);
    checkOutput("bgtz_zero_redirect", {31'b0, bus.Redirect}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 32'h7, 32'h7, 32'h4, 26'h0, 32'h200);
    checkOutput("bne_eq_redirect", {31'b0, bus.Redirect}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h7, 32'h7, 32'h4, 26'h0, 32'h200);
    checkOutput("bad_op_redirect", {31'b0, bus.Redirect}, 32'h0);
    tick();
    clearControl();
    checkOutput("not_taken_pc", bus.PC, 32'h118);
    checkOutput("link_no_jump", {31'b0, bus.LinkWrite}, 32'h0);

    // jal: {0x0, 0x0100000, 00} = 0x00400000
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 26'h0100000, 32'h00400024);
    checkOutput("jal_redirect", {31'b0, bus.Redirect}, 32'h1);
    tick();
    clearControl();
    checkOutput("jal_pc", bus.PC, 32'h00400000);
    checkOutput("jal_linkwrite", {31'b0, bus.LinkWrite}, 32'h1);
    checkOutput("jal_linkaddr", bus.LinkAddr, 32'h00400024);
    tick();
    checkOutput("jal_linkwrite_end", {31'b0, bus.LinkWrite}, 32'h0);
    checkOutput("jal_linkaddr_hold", bus.LinkAddr, 32'h00400024);
    checkOutput("jal_after_pc", bus.PC, 32'h00400004);

    // jr under a two-cycle stall
    bus.Stall = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h1003, 32'h0, 32'h0, 26'h0, 32'h0);
    checkOutput("jr_stall_redirect", {31'b0, bus.Redirect}, 32'h0);
    tick();
    checkOutput("jr_stall_pc1", bus.PC, 32'h00400004);
    tick();
    checkOutput("jr_stall_pc2", bus.PC, 32'h00400004);
    bus.Stall = 1'b0;
    #1;
    checkOutput("jr_release_redirect", {31'b0, bus.Redirect}, 32'h1);
    tick();
    clearControl();
    checkOutput("jr_pc", bus.PC, 32'h1000);
    checkOutput("jr_flush", {31'b0, bus.Flush}, 32'h1);

    // Taken branch offered during FLUSH is ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 32'h3, 32'h3, 32'h10, 26'h0, 32'h2000);
    checkOutput("flush_ignore_redirect", {31'b0, bus.Redirect}, 32'h0);
    tick();
    clearControl();
    checkOutput("flush_ignore_pc", bus.PC, 32'h1004);
    checkOutput("flush_ignore_flush", {31'b0, bus.Flush}, 32'h0);

    // Reset during FLUSH aborts it
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 26'h40, 32'h2000);
    tick();
    clearControl();
    checkOutput("j_pc", bus.PC, 32'h100);
    checkOutput("j_flush", {31'b0, bus.Flush}, 32'h1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkOutput("flush_reset_pc", bus.PC, 32'h0);
    checkOutput("flush_reset_flush", {31'b0, bus.Flush}, 32'h0);
    checkOutput("flush_reset_linkaddr", bus.LinkAddr, 32'h0);

    // PC wrap-around from 0xFFFFFFFC
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 32'hFFFFFFFF, 32'h0, 32'h0, 26'h0, 32'h0);
    tick();
    clearControl();
    checkOutput("wrap_pc", bus.PC, 32'hFFFFFFFC);
    checkOutput("wrap_pcplus4", bus.PCPlus4, 32'h0);
    tick();
    checkOutput("wrap_pc_next", bus.PC, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have the port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port Reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port InstrValid, input, 1 bit: the decode-stage control inputs are meaningful this cycle.
REQ-004 The block SHALL have the port Stall, input, 1 bit: hazard hold; freezes the PC.
REQ-005 The block SHALL have the ports Branch, Jump, JumpRegister and Link, inputs, 1 bit each: decode-stage control.
REQ-006 The block SHALL have the port ALUOp, input, 4 bits: branch condition code. 1011 beq, 1100 bne, 1101 bgtz, 1110 blez, 1010 bgez, 1111 bltz.
REQ-007 The block SHALL have the ports RsData and RtData, inputs, 32 bits each: register operands.
REQ-008 The block SHALL have the port Imm, input, 32 bits: sign-extended immediate.
REQ-009 The block SHALL have the port Target, input, 26 bits: jump index field.
REQ-010 The block SHALL have the port ID_PC4, input, 32 bits: PC+4 of the decode-stage instruction.
REQ-011 The block SHALL have the port PC, output, 32 bits: registered fetch address.
REQ-012 The block SHALL have the port PCPlus4, output, 32 bits: PC+4, combinational from PC.
REQ-013 The block SHALL have the port Flush, output, 1 bit: registered; squash the IF/ID instruction.
REQ-014 The block SHALL have the port LinkWrite, output, 1 bit: registered one-cycle pulse requesting a write of $31.
REQ-015 The block SHALL have the port LinkAddr, output, 32 bits: registered return address.
REQ-016 The block SHALL have the port Redirect, output, 1 bit: combinational; a taken control transfer is accepted this cycle.

Function
REQ-017 The block SHALL implement an FSM with 2 states: RUN and FLUSH.
REQ-018 The block SHALL define an accepted request as InstrValid=1 AND Stall=0 AND state=RUN; all other cycles SHALL ignore the control inputs.
REQ-019 The block SHALL evaluate branch conditions as signed 32-bit: beq Rs==Rt; bne Rs!=Rt; bgtz Rs>0; blez Rs<=0; bgez Rs>=0; bltz Rs<0.
REQ-020 The block SHALL treat an unlisted ALUOp with Branch=1 as not taken.
REQ-021 The block SHALL set Taken = Jump OR (Branch AND condition true).
REQ-022 When Jump=1, the block SHALL ignore Branch.
REQ-023 The block SHALL compute the jump target as {ID_PC4[31:28], Target, 2'b00}.
REQ-024 The block SHALL compute the jr target as {RsData[31:2], 2'b00} when Jump=1 and JumpRegister=1.
REQ-025 The block SHALL compute the branch target as ID_PC4 + (Imm << 2), modulo 2^32 (wrap-around, no trap).
REQ-026 For the next-PC update, the block SHALL apply this priority: Reset, then Stall (PC holds), then accepted Taken (PC <= target), then PC <= PC+4.
REQ-027 PC+4 SHALL wrap from 0xFFFFFFFC to 0x00000000.
REQ-028 On an accepted Taken, the block SHALL assert Redirect=1 in the same cycle and SHALL move to FLUSH at the next edge with Flush=1.
REQ-029 The block SHALL hold FLUSH and Flush=1 for exactly one cycle, then return to RUN with Flush=0.
REQ-030 Stall SHALL NOT extend FLUSH.
REQ-031 While in FLUSH, PC SHALL advance by +4 unless Stall=1.
REQ-032 On an accepted request with Link=1 and Jump=1, the block SHALL, at the next edge, set LinkWrite=1 for one cycle with LinkAddr=ID_PC4 (no delay slot).
REQ-033 The block SHALL keep LinkAddr at its last value otherwise.
REQ-034 Link without Jump SHALL have no effect.
REQ-035 The block SHALL ignore redirect requests arriving while in FLUSH, since the decode instruction is squashed.
REQ-036 Stall=1 with a taken request SHALL produce no redirect; the request SHALL be re-evaluated when Stall falls.

Reset
REQ-037 On Reset=1 at a rising edge, the block SHALL set PC=0x00000000, state=RUN, Flush=0, LinkWrite=0 and LinkAddr=0, overriding any simultaneous Stall or Taken.
REQ-038 A Reset asserted while in FLUSH SHALL abort the flush, with Flush=0 on the next cycle.

Verification
REQ-039 The bench SHALL cover: Reset, then 3 idle cycles -> PC=0, 4, 8, 0xC; Flush=0 throughout.
REQ-040 The bench SHALL cover: beq with Rs=Rt=5, ID_PC4=0x10, Imm=0xFFFFFFFE -> Redirect=1; next PC=0x08; Flush=1 for one cycle; then PC=0x0C.
REQ-041 The bench SHALL cover: bltz with Rs=0x80000000 -> taken; bgtz with Rs=0 -> not taken, PC+4.
REQ-042 The bench SHALL cover: jal with ID_PC4=0x00400024 and Target=0x0100000 -> PC=0x00400000; LinkWrite pulse with LinkAddr=0x00400024.
REQ-043 The bench SHALL cover: jr with Rs=0x1003 and Stall=1 for 2 cycles -> PC holds and no Redirect; when Stall falls, PC=0x1000.
REQ-044 The bench SHALL cover: a taken branch in the FLUSH cycle -> ignored, PC+4; and Reset during FLUSH -> PC=0, Flush=0.
